// File: rtl/dps_periph_router.sv
// dps_periph_router
//   Front end between the core's DPS port and P_CH peripheral windows.
//   Decodes each request into a channel window, tracks one outstanding read
//   (with a response timeout), and funnels per-channel level IRQs into a
//   single CPU IRQ request/acknowledge handshake.
//
// Handshakes:
//   DPS request : accepted when iDPS_REQ && !oDPS_BUSY in the same cycle.
//   Channel req : oCH_REQ one-hot, combinational in the accept cycle.
//   Read return : oDPS_VALID is a one-cycle strobe; oDPS_ERR/oDPS_DATA are
//                 meaningful only while it is high.
//   IRQ         : oDPS_IRQ_REQ held until iDPS_IRQ_ACK, which produces a
//                 one-cycle oCH_IRQ_ACK to the granted source.
//
// Ports:
//   iCLOCK, inRESET              clock, async active-low reset
//   iDPS_* / oDPS_*              CPU side request, read return and IRQ
//   oCH_* / iCH_*                peripheral side (broadcast + per-channel)
//   oDBG_RD_STATE, oDBG_IRQ_STATE  FSM state for observation
//
// Configuration macro:
//   DPS_ROUTER_IRQ_RR_EN  defined: round-robin IRQ arbitration;
//                         undefined: fixed priority, lowest index wins.
module dps_periph_router #(
    parameter int          P_CH       = 4,
    parameter int          P_WIN_LOG2 = 8,
    parameter int          P_TIMEOUT  = 255,
    parameter logic [5:0]  P_IRQ_BASE = 6'h36
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iDPS_REQ,
    output logic                  oDPS_BUSY,
    input  logic                  iDPS_RW,
    input  logic [31:0]           iDPS_ADDR,
    input  logic [31:0]           iDPS_DATA,
    output logic                  oDPS_VALID,
    output logic [31:0]           oDPS_DATA,
    output logic                  oDPS_ERR,
    output logic [P_CH-1:0]       oCH_REQ,
    input  logic [P_CH-1:0]       iCH_BUSY,
    output logic                  oCH_RW,
    output logic [P_WIN_LOG2-1:0] oCH_ADDR,
    output logic [31:0]           oCH_DATA,
    input  logic [P_CH-1:0]       iCH_VALID,
    input  logic [32*P_CH-1:0]    iCH_DATA,
    input  logic [P_CH-1:0]       iCH_IRQ,
    output logic [P_CH-1:0]       oCH_IRQ_ACK,
    output logic                  oDPS_IRQ_REQ,
    output logic [5:0]            oDPS_IRQ_NUM,
    input  logic                  iDPS_IRQ_ACK,
    output logic [1:0]            oDBG_RD_STATE,
    output logic                  oDBG_IRQ_STATE
);

    localparam int CH_W = (P_CH > 1) ? $clog2(P_CH) : 1;
    typedef logic [CH_W-1:0] ch_idx_t;

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_ERR = 2'd2} rd_state_e;
    typedef enum logic       {IRQ_IDLE = 1'b0, IRQ_REQ = 1'b1} irq_state_e;

    rd_state_e  rd_state_q, rd_state_d;
    ch_idx_t    rd_ch_q, rd_ch_d;
    logic [15:0] cnt_q, cnt_d;
    irq_state_e irq_state_q, irq_state_d;
    ch_idx_t    g_q, g_d;
    ch_idx_t    pick;

    logic [31:0] sel;
    ch_idx_t     sel_idx;
    logic        mapped;
    logic        accept;

    assign oCH_RW   = iDPS_RW;
    assign oCH_ADDR = iDPS_ADDR[P_WIN_LOG2-1:0];
    assign oCH_DATA = iDPS_DATA;

    assign sel     = iDPS_ADDR >> P_WIN_LOG2;
    assign sel_idx = sel[CH_W-1:0];
    assign mapped  = (sel < 32'(P_CH));

    assign oDPS_BUSY = (rd_state_q != RD_IDLE) || (|iCH_BUSY);
    // Gating with inRESET keeps oCH_REQ low while reset is held.
    assign accept    = iDPS_REQ && !oDPS_BUSY && inRESET;

    assign oDBG_RD_STATE  = rd_state_q;
    assign oDBG_IRQ_STATE = irq_state_q;

    // ---------------- read path ----------------
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ch_d    = rd_ch_q;
        cnt_d      = cnt_q;
        oCH_REQ    = '0;
        oDPS_VALID = 1'b0;
        oDPS_ERR   = 1'b0;
        oDPS_DATA  = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (accept) begin
                    if (mapped) begin
                        oCH_REQ[sel_idx] = 1'b1;
                        if (!iDPS_RW) begin
                            rd_ch_d    = sel_idx;
                            cnt_d      = '0;
                            rd_state_d = RD_WAIT;
                        end
                    end else if (!iDPS_RW) begin
                        rd_state_d = RD_ERR;
                    end
                end
            end
            RD_WAIT: begin
                // A valid arriving in the expiry cycle still wins.
                if (iCH_VALID[rd_ch_q]) begin
                    oDPS_VALID = 1'b1;
                    oDPS_DATA  = iCH_DATA[int'(rd_ch_q)*32 +: 32];
                    rd_state_d = RD_IDLE;
                end else if (cnt_q == 16'(P_TIMEOUT - 1)) begin
                    rd_state_d = RD_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RD_ERR: begin
                oDPS_VALID = 1'b1;
                oDPS_ERR   = 1'b1;
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // ---------------- IRQ arbitration ----------------
`ifdef DPS_ROUTER_IRQ_RR_EN
    ch_idx_t ptr_q, ptr_d;

    // Search upward from the pointer, wrapping at P_CH; first hit wins.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < P_CH; i++) begin
            if (!found && iCH_IRQ[(int'(ptr_q) + i) % P_CH]) begin
                pick  = ch_idx_t'((int'(ptr_q) + i) % P_CH);
                found = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest set index is the last write.
    always_comb begin
        pick = '0;
        for (int i = P_CH - 1; i >= 0; i--) begin
            if (iCH_IRQ[i]) pick = ch_idx_t'(i);
        end
    end
`endif

    always_comb begin
        irq_state_d  = irq_state_q;
        g_d          = g_q;
        oCH_IRQ_ACK  = '0;
        oDPS_IRQ_REQ = 1'b0;
`ifdef DPS_ROUTER_IRQ_RR_EN
        ptr_d        = ptr_q;
`endif
        case (irq_state_q)
            IRQ_IDLE: begin
                if (|iCH_IRQ) begin
                    g_d         = pick;
                    irq_state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                oDPS_IRQ_REQ = 1'b1;
                if (iDPS_IRQ_ACK) begin
                    oCH_IRQ_ACK[g_q] = 1'b1;
                    irq_state_d      = IRQ_IDLE;
`ifdef DPS_ROUTER_IRQ_RR_EN
                    ptr_d = (int'(g_q) == P_CH - 1) ? '0 : g_q + ch_idx_t'(1);
`endif
                end
            end
            default: irq_state_d = IRQ_IDLE;
        endcase
    end

    // g resets to 0, so the number reads P_IRQ_BASE whenever reset is held.
    assign oDPS_IRQ_NUM = P_IRQ_BASE + 6'(g_q);

    // ---------------- state registers ----------------
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_state_q  <= RD_IDLE;
            rd_ch_q     <= '0;
            cnt_q       <= '0;
            irq_state_q <= IRQ_IDLE;
            g_q         <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_ch_q     <= rd_ch_d;
            cnt_q       <= cnt_d;
            irq_state_q <= irq_state_d;
            g_q         <= g_d;
        end
    end

`ifdef DPS_ROUTER_IRQ_RR_EN
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

endmodule

// File: tb/tb_dps_periph_router.sv
// Bench for dps_periph_router (P_CH=4, P_WIN_LOG2=8, P_TIMEOUT=16).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. "Cycle N" is the Nth clock period after the accept cycle.
module tb_dps_periph_router;

    localparam int         CH   = 4;
    localparam int         WL   = 8;
    localparam int         TMO  = 16;
    localparam logic [5:0] BASE = 6'h36;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dps_req, dps_busy, dps_rw;
    logic [31:0]       dps_addr, dps_wdata;
    logic              dps_valid, dps_err;
    logic [31:0]       dps_rdata;
    logic [CH-1:0]     ch_req, ch_busy, ch_valid, ch_irq, ch_irq_ack;
    logic              ch_rw;
    logic [WL-1:0]     ch_addr;
    logic [31:0]       ch_wdata;
    logic [32*CH-1:0]  ch_rdata;
    logic              irq_req, irq_ack;
    logic [5:0]        irq_num;
    logic [1:0]        dbg_rd;
    logic              dbg_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dps_periph_router #(
        .P_CH(CH), .P_WIN_LOG2(WL), .P_TIMEOUT(TMO), .P_IRQ_BASE(BASE)
    ) dut (
        .iCLOCK(clk), .inRESET(rst_n),
        .iDPS_REQ(dps_req), .oDPS_BUSY(dps_busy), .iDPS_RW(dps_rw),
        .iDPS_ADDR(dps_addr), .iDPS_DATA(dps_wdata),
        .oDPS_VALID(dps_valid), .oDPS_DATA(dps_rdata), .oDPS_ERR(dps_err),
        .oCH_REQ(ch_req), .iCH_BUSY(ch_busy), .oCH_RW(ch_rw),
        .oCH_ADDR(ch_addr), .oCH_DATA(ch_wdata),
        .iCH_VALID(ch_valid), .iCH_DATA(ch_rdata),
        .iCH_IRQ(ch_irq), .oCH_IRQ_ACK(ch_irq_ack),
        .oDPS_IRQ_REQ(irq_req), .oDPS_IRQ_NUM(irq_num), .iDPS_IRQ_ACK(irq_ack),
        .oDBG_RD_STATE(dbg_rd), .oDBG_IRQ_STATE(dbg_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Arbitration rule as stated: lowest pending index, or (round-robin)
    // first pending index at or after the pointer, wrapping.
    function automatic int model_pick(input logic [CH-1:0] lines, input int ptr);
        for (int i = 0; i < CH; i++) begin
`ifdef DPS_ROUTER_IRQ_RR_EN
            if (lines[(ptr + i) % CH]) return (ptr + i) % CH;
`else
            if (lines[i]) return i;
`endif
        end
        return 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; dps_req = 1'b1; dps_rw = 1'b0; dps_addr = 32'h100;
        dps_wdata = '0; ch_busy = 4'b0100; ch_valid = 4'b1111;
        ch_rdata = '1; ch_irq = 4'b0001; irq_ack = 1'b1;
        sample();
        checks++; if (ch_req !== 4'b0) begin errors++; $display("FAIL reset_ch_req got=%b exp=0000", ch_req); end
        checks++; if (dps_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_hi got=%b exp=1", dps_busy); end
        checks++; if ({dps_valid, dps_err, dps_rdata} !== 34'b0) begin errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0", dps_valid, dps_err, dps_rdata); end
        checks++; if ({irq_req, ch_irq_ack} !== 5'b0) begin errors++; $display("FAIL reset_irq got req=%b ack=%b exp 0", irq_req, ch_irq_ack); end
        checks++; if (irq_num !== BASE) begin errors++; $display("FAIL reset_irq_num got=%h exp=%h", irq_num, BASE); end
        tick();
        ch_busy = 4'b0;
        sample();
        checks++; if (dps_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_lo got=%b exp=0", dps_busy); end
        tick();
        dps_req = 1'b0; ch_valid = '0; ch_irq = '0; irq_ack = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] sel_w;
        logic [CH-1:0] exp_req;
        sel_w   = addr >> WL;
        exp_req = (sel_w < CH) ? 4'(1 << sel_w[1:0]) : 4'b0;
        tick();
        dps_req = 1'b1; dps_rw = 1'b1; dps_addr = addr; dps_wdata = data;
        sample();
        checks++; if (ch_req !== exp_req) begin errors++; $display("FAIL wr_ch_req addr=%h got=%b exp=%b", addr, ch_req, exp_req); end
        checks++; if ({ch_rw, ch_addr, ch_wdata} !== {1'b1, addr[WL-1:0], data}) begin errors++; $display("FAIL wr_bcast got rw=%b a=%h d=%h exp rw=1 a=%h d=%h", ch_rw, ch_addr, ch_wdata, addr[WL-1:0], data); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            dps_req = 1'b0;
            sample();
            checks++; if ({dps_valid, dps_busy} !== 2'b00) begin errors++; $display("FAIL wr_quiet c=%0d got v=%b busy=%b exp 00", c, dps_valid, dps_busy); end
        end
    endtask

    // d: cycle in which the owning channel pulses valid (0 = never).
    task automatic run_read(input logic [31:0] addr, input int d,
                            input logic [31:0] rdata, input bit noise);
        logic [31:0] sel_w;
        int sel, resp;
        bit mapped, exp_err;
        logic [31:0] exp_data;
        logic [CH-1:0] exp_req;
        sel_w  = addr >> WL;
        mapped = (sel_w < CH);
        sel    = int'(sel_w[1:0]);
        if (!mapped) begin
            resp = 1; exp_err = 1'b1; exp_data = '0;
        end else if (d >= 1 && d <= TMO) begin
            resp = d; exp_err = 1'b0; exp_data = rdata;
        end else begin
            resp = TMO + 1; exp_err = 1'b1; exp_data = '0;
        end
        exp_req = mapped ? 4'(1 << sel) : 4'b0;
        tick();
        dps_req = 1'b1; dps_rw = 1'b0; dps_addr = addr; dps_wdata = $urandom;
        sample();
        checks++; if (ch_req !== exp_req) begin errors++; $display("FAIL rd_ch_req addr=%h got=%b exp=%b", addr, ch_req, exp_req); end
        checks++; if ({dps_busy, dps_valid} !== 2'b00) begin errors++; $display("FAIL rd_accept addr=%h got busy=%b v=%b exp 00", addr, dps_busy, dps_valid); end
        for (int c = 1; c <= resp + 1; c++) begin
            tick();
            dps_req  = 1'b0;
            ch_valid = '0;
            ch_rdata = {$urandom, $urandom, $urandom, $urandom};
            ch_rdata[sel*32 +: 32] = rdata;
            if (mapped && c == d) ch_valid[sel] = 1'b1;
            if (noise && $urandom_range(0, 1) == 1) ch_valid[(sel + 1) % CH] = 1'b1;
            sample();
            checks++; if (dps_valid !== (c == resp)) begin errors++; $display("FAIL rd_valid addr=%h c=%0d got=%b exp=%b", addr, c, dps_valid, c == resp); end
            checks++; if (dps_busy !== (c <= resp)) begin errors++; $display("FAIL rd_busy addr=%h c=%0d got=%b exp=%b", addr, c, dps_busy, c <= resp); end
            if (c == resp) begin
                checks++; if ({dps_err, dps_rdata} !== {exp_err, exp_data}) begin errors++; $display("FAIL rd_resp addr=%h got e=%b d=%h exp e=%b d=%h", addr, dps_err, dps_rdata, exp_err, exp_data); end
            end else begin
                checks++; if ({dps_err, dps_rdata} !== 33'b0) begin errors++; $display("FAIL rd_idle_out addr=%h c=%0d got e=%b d=%h exp 0", addr, c, dps_err, dps_rdata); end
            end
        end
        tick();
        ch_valid = '0;
    endtask

    task automatic test_write();
        run_write(32'h104, 32'hA5);
        run_write(32'h400, 32'hDEAD_BEEF);
        run_write(32'h3FF, 32'h0123_4567);
    endtask

    task automatic test_read();
        run_read(32'h208, 3, 32'h1234_5678, 1'b1);
        run_read(32'h000, 1, 32'hCAFE_0001, 1'b0);
        run_read(32'h400, 1, 32'h0, 1'b0);
        run_read(32'hFFFF_FF00, 0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        run_read(32'h300, 0, 32'h5555_AAAA, 1'b1);
        run_read(32'h300, TMO, 32'h8765_4321, 1'b0);
        run_read(32'h1F0, TMO + 1, 32'h1111_2222, 1'b0);
    endtask

    task automatic test_busy();
        tick();
        ch_busy = 4'b0010; dps_req = 1'b1; dps_rw = 1'b0; dps_addr = 32'h100;
        sample();
        checks++; if ({dps_busy, ch_req} !== {1'b1, 4'b0}) begin errors++; $display("FAIL busy_block got busy=%b req=%b exp 1 0000", dps_busy, ch_req); end
        tick();
        ch_busy = '0; dps_req = 1'b0;
        sample();
        checks++; if ({dps_busy, dps_valid} !== 2'b00) begin errors++; $display("FAIL busy_not_accepted got busy=%b v=%b exp 00", dps_busy, dps_valid); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 30; n++) begin
            addr = {21'b0, 3'($urandom_range(0, 5)), 8'($urandom)};
            if ($urandom_range(0, 2) == 0) run_write(addr, $urandom);
            else run_read(addr, $urandom_range(0, 20), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_irq();
        logic [CH-1:0] lines;
        int ptr, g, n;
        tick();
        irq_ack = 1'b1;
        sample();
        checks++; if ({irq_req, ch_irq_ack} !== 5'b0) begin errors++; $display("FAIL irq_idle_ack got req=%b ack=%b exp 0", irq_req, ch_irq_ack); end
        tick();
        irq_ack = 1'b0; lines = 4'b0011; ch_irq = lines; ptr = 0; n = 0;
        sample();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_first_cycle got=%b exp=0", irq_req); end
        while (lines != 0 && n < 4) begin
            g = model_pick(lines, ptr);
            tick();
            sample();
            checks++; if ({irq_req, irq_num, ch_irq_ack} !== {1'b1, BASE + 6'(g), 4'b0}) begin errors++; $display("FAIL irq_req n=%0d got req=%b num=%h ack=%b exp 1 %h 0000", n, irq_req, irq_num, ch_irq_ack, BASE + 6'(g)); end
            repeat ($urandom_range(0, 2)) begin
                tick();
                sample();
                checks++; if ({irq_req, irq_num} !== {1'b1, BASE + 6'(g)}) begin errors++; $display("FAIL irq_hold n=%0d got req=%b num=%h", n, irq_req, irq_num); end
            end
            tick();
            irq_ack = 1'b1;
            sample();
            checks++; if (ch_irq_ack !== 4'(1 << g)) begin errors++; $display("FAIL irq_ack n=%0d got=%b exp=%b", n, ch_irq_ack, 4'(1 << g)); end
`ifdef DPS_ROUTER_IRQ_RR_EN
            ptr = (g + 1) % CH;
`else
            lines[g] = 1'b0;
`endif
            tick();
            irq_ack = 1'b0; ch_irq = lines;
            sample();
            checks++; if ({irq_req, ch_irq_ack} !== 5'b0) begin errors++; $display("FAIL irq_gap n=%0d got req=%b ack=%b exp 0", n, irq_req, ch_irq_ack); end
            n++;
        end
        tick();
        ch_irq = '0; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        sample();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_done got=%b exp=0", irq_req); end
    endtask

    task automatic test_reset_mid();
        tick();
        dps_req = 1'b1; dps_rw = 1'b0; dps_addr = 32'h300; ch_irq = 4'b0100;
        tick();
        dps_req = 1'b0;
        tick();
        sample();
        checks++; if ({irq_req, irq_num, dps_busy} !== {1'b1, BASE + 6'd2, 1'b1}) begin errors++; $display("FAIL mid_pre got req=%b num=%h busy=%b", irq_req, irq_num, dps_busy); end
        tick();
        rst_n = 1'b0; ch_irq = '0; dps_req = 1'b1; dps_addr = 32'h100; ch_valid = 4'b1000;
        sample();
        checks++; if ({dps_valid, dps_err, dps_rdata, irq_req, ch_irq_ack, ch_req, dps_busy} !== 43'b0) begin errors++; $display("FAIL mid_reset_out got v=%b e=%b d=%h req=%b ack=%b chreq=%b busy=%b", dps_valid, dps_err, dps_rdata, irq_req, ch_irq_ack, ch_req, dps_busy); end
        checks++; if (irq_num !== BASE) begin errors++; $display("FAIL mid_reset_num got=%h exp=%h", irq_num, BASE); end
        tick();
        dps_req = 1'b0; ch_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        ch_valid = 4'b1000; ch_rdata = '1;
        sample();
        checks++; if ({dps_valid, dps_busy} !== 2'b00) begin errors++; $display("FAIL mid_stale got v=%b busy=%b exp 00", dps_valid, dps_busy); end
        tick();
        ch_valid = '0;
        run_read(32'h004, 2, $urandom, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_busy();
        test_irq();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dps_periph_router.md
# dps_periph_router

Parametrised successor to the fixed three-device DPS front end. It decodes CPU DPS requests into `P_CH` equal-size peripheral windows and tracks one outstanding read. The read-return mux follows the decoded channel only, and a read that gets no response within a bounded time returns an error. It also aggregates per-channel interrupt lines into a single CPU IRQ request/acknowledge handshake. It sits between the core's DPS port and the peripheral instances (UTIM64, SCI, MIMSR, future devices).

## Interface
- `P_CH`, 4: number of channels, 1..16.
- `P_WIN_LOG2`, 8: log2 of window size in bytes.
  - Channel `i` owns addresses `[i<<P_WIN_LOG2, (i+1)<<P_WIN_LOG2)`.
  - Every address at or above `P_CH<<P_WIN_LOG2` is unmapped.
- `P_TIMEOUT`, 255: read-response timeout in cycles, 1..65535.
- `P_IRQ_BASE`, 6'h36: IRQ number reported for channel 0. Constraint: `P_IRQ_BASE+P_CH <= 64`.
- `iCLOCK` in 1: single clock.
- `inRESET` in 1: asynchronous, active-low reset.
- `iDPS_REQ` in 1: request strobe.
- `oDPS_BUSY` out 1: request not accepted this cycle.
- `iDPS_RW` in 1: 1 = write.
- `iDPS_ADDR` in 32: byte address.
- `iDPS_DATA` in 32: write data.
- `oDPS_VALID` out 1: read-response strobe.
- `oDPS_DATA` out 32: read data.
- `oDPS_ERR` out 1: response is an error (unmapped address or timeout); qualified by `oDPS_VALID`.
- `oCH_REQ` out `P_CH`: one-hot request to a channel.
- `iCH_BUSY` in `P_CH`: channel busy.
- `oCH_RW` out 1: broadcast copy of `iDPS_RW`.
- `oCH_ADDR` out `P_WIN_LOG2`: `iDPS_ADDR[P_WIN_LOG2-1:0]`.
- `oCH_DATA` out 32: broadcast copy of `iDPS_DATA`.
- `iCH_VALID` in `P_CH`: per-channel read-return strobe.
- `iCH_DATA` in `32*P_CH`: read data; channel `i` on bits `[32i+31:32i]`.
- `iCH_IRQ` in `P_CH`: level IRQ; held by the source until acknowledged.
- `oCH_IRQ_ACK` out `P_CH`: one-cycle acknowledge to the source.
- `oDPS_IRQ_REQ` out 1: IRQ request to the CPU.
- `oDPS_IRQ_NUM` out 6: IRQ number.
- `iDPS_IRQ_ACK` in 1: CPU acknowledge.

## Operation
**Request path**
- Accept condition: `iDPS_REQ && !oDPS_BUSY`.
- `oDPS_BUSY = (rd_state != RD_IDLE) || |iCH_BUSY`.
- Selected channel: `sel = iDPS_ADDR >> P_WIN_LOG2`. The address is mapped when `sel < P_CH`.
- Accepted mapped request: `oCH_REQ[sel]=1` combinationally in the accept cycle, all other bits 0.

**Request outcomes**
- Write, mapped: forwarded; no response; state stays RD_IDLE.
- Write, unmapped: dropped silently.
- Read, mapped: latch `sel` into `rd_ch`, clear the timeout counter, go to RD_WAIT.
- Read, unmapped: no `oCH_REQ`; go to RD_ERR.

**Read FSM (RD_IDLE, RD_WAIT, RD_ERR)**
- RD_WAIT, `iCH_VALID[rd_ch]=1`:
  - Combinationally: `oDPS_VALID=1`, `oDPS_DATA=iCH_DATA[rd_ch]`, `oDPS_ERR=0`.
  - Next state: RD_IDLE.
- RD_WAIT, valid absent: the counter increments. When the counter reaches `P_TIMEOUT-1` with no valid, go to RD_ERR.
- Valid in the expiry cycle wins: normal response, no error.
- `iCH_VALID` from any channel other than `rd_ch` is ignored.
- `iCH_VALID` is also ignored in RD_IDLE and RD_ERR.
- RD_ERR: `oDPS_VALID=1`, `oDPS_ERR=1`, `oDPS_DATA=0` for one cycle, then RD_IDLE.
- Outside a response cycle, `oDPS_VALID=0`, `oDPS_ERR=0`, `oDPS_DATA=0`.

**IRQ FSM (IRQ_IDLE, IRQ_REQ)**
- IRQ_IDLE, `|iCH_IRQ`: register grant index `g` per the arbitration rule, go to IRQ_REQ.
- IRQ_REQ outputs: `oDPS_IRQ_REQ=1`, `oDPS_IRQ_NUM=P_IRQ_BASE+g`.
- IRQ_REQ, `iDPS_IRQ_ACK`:
  - `oCH_IRQ_ACK[g]=1` combinationally in that cycle.
  - Next state: IRQ_IDLE.
- There is at least one IRQ_IDLE cycle between grants.
- `g` is held even if `iCH_IRQ[g]` drops before the acknowledge.
- `iDPS_IRQ_ACK` in IRQ_IDLE is ignored.
- The request path and the IRQ path are fully independent; simultaneous events in both are both honoured.

**Reset** (asynchronous; applies at any point, including mid-read or mid-IRQ)
- State after reset: RD_IDLE, IRQ_IDLE; counter 0; `g` 0; RR pointer 0.
- Output values during reset:
  - `oDPS_VALID`, `oDPS_ERR`, `oDPS_DATA`, `oDPS_IRQ_REQ`, `oCH_IRQ_ACK` all 0.
  - `oDPS_IRQ_NUM = P_IRQ_BASE`.
  - `oCH_REQ = 0`.
  - `oDPS_BUSY = |iCH_BUSY`.
- A pending read is abandoned. A late `iCH_VALID` after reset is ignored.

## Timing
- Accept in cycle 0: `oCH_REQ` is asserted in cycle 0. `oDPS_BUSY` is high from cycle 1 for reads.
- Read data is returned in the same cycle as `iCH_VALID[rd_ch]`, at the earliest in cycle 1.
- Unmapped read: error response in cycle 1.
- Timeout: error response in cycle `P_TIMEOUT+1` after accept. A new request can be accepted in cycle `P_TIMEOUT+2`.
- IRQ: `oDPS_IRQ_REQ` rises 1 cycle after `iCH_IRQ` is sampled. It falls the cycle after `iDPS_IRQ_ACK`.
- Minimum spacing between back-to-back grants: 2 cycles.

## Configuration
- `DPS_ROUTER_IRQ_RR_EN`:
  - Defined: round-robin arbitration. The search starts at the RR pointer, wrapping at `P_CH`. The pointer becomes `g+1` (mod `P_CH`) on each acknowledge.
  - Undefined: fixed priority, lowest index wins; there is no pointer register.

## Test plan
Settings: `P_CH=4`, `P_WIN_LOG2=8`, `P_TIMEOUT=16`, `P_IRQ_BASE=6'h36`.
- Write 0x104, data 0xA5 -> cycle 0: `oCH_REQ=4'b0010`, `oCH_ADDR=8'h04`, `oCH_RW=1`, `oCH_DATA=0xA5`; `oDPS_VALID` never asserts; `oDPS_BUSY` stays 0.
- Read 0x208; `iCH_VALID[0]` pulses at cycle 2; `iCH_VALID[2]` with 0x12345678 at cycle 3 -> no response at cycle 2; cycle 3: `oDPS_VALID=1`, `oDPS_DATA=0x12345678`, `oDPS_ERR=0`.
- Read 0x300, no channel response -> cycle 17: `oDPS_VALID=1`, `oDPS_ERR=1`, data 0; `oDPS_BUSY=1` in cycles 1..17. Repeat with `iCH_VALID[3]` at cycle 16 -> normal response.
- Read 0x400 -> `oCH_REQ=0`; cycle 1: `oDPS_VALID=1`, `oDPS_ERR=1`. Write 0x400 -> no effect at all.
- `iCH_IRQ=4'b0011` held, CPU acks each request, each source drops only its own line after its ack -> NUM sequence:
  - fixed priority: 0x36, 0x37;
  - `DPS_ROUTER_IRQ_RR_EN` with both lines re-raised immediately: 0x36, 0x37, 0x36, ...
  - `oCH_IRQ_ACK` pulses the matching bit each time.
- `inRESET` low during RD_WAIT and IRQ_REQ, then `iCH_VALID` after release -> all outputs at reset values, stale valid ignored, next read 0x004 completes normally.
